// File: rtl/sram_mbist.sv
// March C- self-test engine and functional access mux in front of a single-port SRAM.
// When idle the system port drives the SRAM; START hands the SRAM to the engine until the pass ends.
module sram_mbist #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] sys_addr,
  input  logic              sys_we,
  input  logic [DATA_W-1:0] sys_din,
  output logic [DATA_W-1:0] sys_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data
);

  // state | meaning
  // IDLE  | no test since reset; SYS port owns the SRAM
  // RD    | engine drives read address, WE=0
  // CMP   | address held, MEM_DOUT checked against the element's read value
  // WR    | engine writes the element's data at the current address
  // FIN   | test finished, DONE/FAIL held; SYS port owns the SRAM again
  typedef enum logic [2:0] {IDLE, RD, CMP, WR, FIN} state_t;

  localparam logic [DATA_W-1:0] D0 = '0;
  localparam logic [DATA_W-1:0] D1 = '1;
  localparam logic [2:0]        ELEM_LAST = 3'd5;

  state_t              state;
  logic [2:0]          elem;
  logic [ADDR_W-1:0]   addr;
  logic                eng_we;
  logic [DATA_W-1:0]   eng_din;

  logic                last_addr;
  logic [ADDR_W-1:0]   step_addr;
  logic [2:0]          elem_nxt;
  logic                mismatch;

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic has_write(input logic [2:0] e);
    return e != ELEM_LAST;
  endfunction

  function automatic logic [DATA_W-1:0] wr_data(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? D1 : D0;
  endfunction

  function automatic logic [DATA_W-1:0] rd_expect(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? D1 : D0;
  endfunction

  function automatic logic [ADDR_W-1:0] first_addr(input logic [2:0] e);
    return is_down(e) ? '1 : '0;
  endfunction

  assign last_addr = is_down(elem) ? (addr == '0) : (addr == '1);
  assign step_addr = is_down(elem) ? (addr - 1'b1) : (addr + 1'b1);
  assign elem_nxt  = elem + 3'd1;
  assign mismatch  = (mem_dout != rd_expect(elem));

  // Combinational on busy so the SYS port regains the SRAM in the same cycle busy drops.
  assign mem_addr = busy ? addr    : sys_addr;
  assign mem_we   = busy ? eng_we  : sys_we;
  assign mem_din  = busy ? eng_din : sys_din;
  assign sys_dout = mem_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      elem      <= '0;
      addr      <= '0;
      eng_we    <= 1'b0;
      eng_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state     <= WR;
            elem      <= '0;
            addr      <= '0;
            eng_we    <= 1'b1;
            eng_din   <= D0;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
          end
        end
        RD: begin
          state  <= CMP;
          eng_we <= 1'b0;
        end
        CMP: begin
          if (mismatch) begin
            // Stop on first fail: record where and what, and release the SRAM.
            fail      <= 1'b1;
            fail_addr <= addr;
            fail_elem <= elem;
            fail_data <= mem_dout;
            state     <= FIN;
            eng_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (!has_write(elem)) begin
            if (last_addr) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              addr  <= step_addr;
              state <= RD;
            end
          end else begin
            state   <= WR;
            eng_we  <= 1'b1;
            eng_din <= wr_data(elem);
          end
        end
        WR: begin
          if (last_addr) begin
            // Every element after E0 opens with a read.
            elem   <= elem_nxt;
            addr   <= first_addr(elem_nxt);
            state  <= RD;
            eng_we <= 1'b0;
          end else begin
            addr <= step_addr;
            if (elem == 3'd0) begin
              state  <= WR;
              eng_we <= 1'b1;
            end else begin
              state  <= RD;
              eng_we <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          eng_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_mbist.md
# sram_mbist

March C- built-in self-test engine and access mux placed directly upstream of the 1024x8 single-port `SRAM`. When idle it passes the system port (`SYS_*`) through to the SRAM. On `START` it takes the SRAM over and runs a full March C- pass, then reports pass/fail with the first failing address, element and read data. It also serves as the functional-access front end, so the SRAM is never driven from two sources.

## Interface
- `ADDR_W`, 10, SRAM address width; depth = 2**ADDR_W.
- `DATA_W`, 8, SRAM data width.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `START`  in  1  one-cycle test request; sampled only in IDLE or DONE.
- `SYS_ADDR`  in  ADDR_W  functional address.
- `SYS_WE`  in  1  functional write enable.
- `SYS_DIN`  in  DATA_W  functional write data.
- `SYS_DOUT`  out  DATA_W  functional read data; wire from `MEM_DOUT`.
- `MEM_ADDR`  out  ADDR_W  to SRAM `ADDR`.
- `MEM_WE`  out  1  to SRAM `WE`.
- `MEM_DIN`  out  DATA_W  to SRAM `DIN`.
- `MEM_DOUT`  in  DATA_W  from SRAM `DOUT`.
- `BUSY`  out  1  test in progress; the SYS port is ignored while this is high.
- `DONE`  out  1  sticky; set at test end and held until the next START.
- `FAIL`  out  1  sticky; valid when DONE=1.
- `FAIL_ADDR`  out  ADDR_W  address of the first mismatch.
- `FAIL_ELEM`  out  3  March element (0-5) of the first mismatch.
- `FAIL_DATA`  out  DATA_W  observed `MEM_DOUT` at the first mismatch.

## Operation
- SRAM contract: a write occurs at the CLK edge when WE=1. The read is registered, so `DOUT` shows mem[ADDR sampled at edge N] after edge N, giving 1-cycle read latency.
- Mux: BUSY=0 gives `MEM_*`=`SYS_*`. BUSY=1 gives `MEM_*` from the engine. The mux is combinational on BUSY.
- March C- elements. D0 is all-zeros and D1 is all-ones (DATA_W bits).
  - E0 up(w D0)
  - E1 up(r D0, w D1)
  - E2 up(r D1, w D0)
  - E3 down(r D0, w D1)
  - E4 down(r D1, w D0)
  - E5 up(r D0)
- Up order runs 0 to DEPTH-1; down order runs DEPTH-1 to 0. The address counter reloads at each element boundary and never wraps mid-element.
- FSM states: IDLE, RD, CMP, WR, FIN.
  - RD: drive address with WE=0.
  - CMP: hold the address and compare `MEM_DOUT` against the expected value.
  - WR: drive the address, WE=1, and the element's write data.
  - E0 uses WR only; E5 uses RD/CMP only; E1-E4 use RD, CMP, WR per address.
  - After the last op of the last address of an element: advance the element index and reload the address. After E5 go to FIN.
- Mismatch in CMP:
  - Capture FAIL_ADDR, FAIL_ELEM and FAIL_DATA.
  - Set FAIL=1 and go straight to FIN, aborting the test (stop-on-first-fail).
  - No write occurs in that cycle.
- FIN: BUSY=0, DONE=1. Return to IDLE-equivalent mux behaviour while DONE stays asserted.
- START in IDLE or DONE clears DONE, FAIL and the FAIL_* outputs, then begins E0 at address 0. START while BUSY is ignored.
- Simultaneous START and SYS access: START wins. The SYS access in that cycle is still passed through, because BUSY is still 0.

## Timing
- Reset (async, RST_N=0):
  - State goes to IDLE.
  - BUSY=0, DONE=0, FAIL=0, FAIL_ADDR=0, FAIL_ELEM=0, FAIL_DATA=0.
  - The engine address and element counters go to 0.
  - `MEM_*` follow `SYS_*` immediately.
- Reset mid-test aborts with no further engine writes. Memory contents are undefined afterwards.
- START sampled at edge E0 sets BUSY=1 after E0, and the first engine op is driven in the cycle after E0.
- Op cycles per address:
  - E0: 1
  - E1-E4: 3
  - E5: 2
- Total on a passing run: 15 x DEPTH = 15360 cycles. DONE=1 and BUSY=0 after edge E0+15360.
- On a fail, DONE rises at the edge that ends the failing CMP cycle.
- FAIL_ELEM and the other FAIL_* outputs are registered and change only at that edge.
- Compare in CMP uses `MEM_DOUT` as seen in that cycle, which holds data for the address issued in the preceding RD cycle.

## Test plan
- Fault-free SRAM, pulse START → BUSY=1 for 15360 cycles, then DONE=1 and FAIL=0; all 1024 locations read 0x00 afterwards through the SYS port.
- Address 5 bit 3 stuck-at-0 → DONE=1, FAIL=1, FAIL_ELEM=2, FAIL_ADDR=5, FAIL_DATA=0xF7, with BUSY dropping at cycle 1024+3x1024+3x5+2.
- Idle bypass: SYS write 0xAA at address 5 with WE=1 for one cycle, then SYS read address 5 → `SYS_DOUT`=0xAA one cycle later; BUSY stays 0.
- START pulsed again at cycle 3000 of a run, and SYS_WE=1 with SYS_ADDR=7 and data 0x55 applied during BUSY → no restart, `MEM_WE`/`MEM_ADDR` remain engine-driven, and the run completes at 15360 with FAIL=0.
- RST_N low at cycle 5000 → BUSY, DONE and FAIL go to 0 immediately and `MEM_WE` follows SYS_WE; a following START gives a full pass.
- After a failing run, inject no fault and START again → FAIL and FAIL_* clear the cycle after START, and the run ends with DONE=1, FAIL=0.
